// File: rtl/rsa_msg_sequencer_if.sv
// Bus bundle between the RSA message sequencer, the host, the exponentiation core
// and the result consumer. clk and aresetn stay outside as plain ports.
interface rsa_msg_sequencer_if #(
  parameter int BITS = 32
);
  logic            key_we;
  logic [BITS-1:0] key_e;
  logic [BITS-1:0] key_n;
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic [BITS-1:0] rsa_m;
  logic [BITS-1:0] rsa_e;
  logic [BITS-1:0] rsa_n;
  logic            rsa_go;
  logic [BITS-1:0] rsa_r;
  logic            rsa_d;
  logic            out_valid;
  logic [BITS-1:0] out_data;
  logic            out_err;
  logic            out_ready;
  logic            busy;
  logic            key_err;
  logic [15:0]     done_count;

  modport master (
    output key_we, key_e, key_n, in_valid, in_data, rsa_r, rsa_d, out_ready,
    input  in_ready, rsa_m, rsa_e, rsa_n, rsa_go, out_valid, out_data, out_err,
           busy, key_err, done_count
  );

  modport slave (
    input  key_we, key_e, key_n, in_valid, in_data, rsa_r, rsa_d, out_ready,
    output in_ready, rsa_m, rsa_e, rsa_n, rsa_go, out_valid, out_data, out_err,
           busy, key_err, done_count
  );
endinterface

// File: rtl/rsa_msg_sequencer.sv
// Feeds buffered message words one at a time into the RSA exponentiation core and
// returns each result (or an error word) on a valid/ready stream.
module rsa_msg_sequencer #(
  parameter int BITS    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input logic                clk,
  input logic                aresetn,
  rsa_msg_sequencer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CHECK = 4'b0010,
    S_RUN   = 4'b0100,
    S_OUT   = 4'b1000
  } state_t;

  state_t          r_state;
  logic [BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_in_ready;
  logic [BITS-1:0] r_key_e;
  logic [BITS-1:0] r_key_n;
  logic            r_key_valid;
  logic            r_key_err;
  logic [BITS-1:0] r_rsa_m;
  logic            r_go;
  logic [TW-1:0]   r_tmo;
  logic            r_out_valid;
  logic [BITS-1:0] r_out_data;
  logic            r_out_err;
  logic [15:0]     r_done_count;
  logic            w_busy;
  logic            w_push;
  logic            w_pop;
  logic            w_key_ok;
  logic            w_key_bad;
  logic            w_hs;

  assign w_busy    = (r_state != S_IDLE);
  assign w_push    = bus.in_valid & r_in_ready;
  assign w_pop     = (r_state == S_IDLE) & r_key_valid & (r_count != CW'(0));
  assign w_key_ok  = bus.key_we & ~w_busy & (bus.key_n >= BITS'(2));
  assign w_key_bad = bus.key_we & (w_busy | (bus.key_n < BITS'(2)));
  assign w_hs      = r_out_valid & bus.out_ready;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // FIFO pointers, count and registered not-full flag
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr   <= PW'(0);
      r_rd_ptr   <= PW'(0);
      r_count    <= CW'(0);
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // Public key latch and sticky key error
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_key_e     <= BITS'(0);
      r_key_n     <= BITS'(0);
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      if (w_key_ok) begin
        r_key_e     <= bus.key_e;
        r_key_n     <= bus.key_n;
        r_key_valid <= 1'b1;
      end
      if (w_key_bad) r_key_err <= 1'b1;
    end
  end

  // Operation sequencer; go stays low through CHECK so the core sees a full reset cycle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_rsa_m      <= BITS'(0);
      r_go         <= 1'b0;
      r_tmo        <= TW'(0);
      r_out_valid  <= 1'b0;
      r_out_data   <= BITS'(0);
      r_out_err    <= 1'b0;
      r_done_count <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_go <= 1'b0;
          if (w_pop) begin
            r_rsa_m <= r_mem[r_rd_ptr];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_rsa_m >= r_key_n) begin
            r_out_data  <= r_rsa_m;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_go    <= 1'b1;
            r_tmo   <= TW'(0);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.rsa_d) begin
            r_out_data  <= bus.rsa_r;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_go        <= 1'b0;
            r_state     <= S_OUT;
          end else if (r_tmo == TMO_LAST) begin
            r_out_data  <= BITS'(0);
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_go        <= 1'b0;
            r_state     <= S_OUT;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_OUT: begin
          r_go <= 1'b0;
          if (w_hs) begin
            r_out_valid  <= 1'b0;
            r_done_count <= r_done_count + 16'd1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_go        <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.rsa_m      = r_rsa_m;
  assign bus.rsa_e      = r_key_e;
  assign bus.rsa_n      = r_key_n;
  assign bus.rsa_go     = r_go;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_err    = r_out_err;
  assign bus.busy       = w_busy;
  assign bus.key_err    = r_key_err;
  assign bus.done_count = r_done_count;
endmodule

// File: doc/rsa_msg_sequencer.md
Name: rsa_msg_sequencer

Overview:
Upstream feeder and result collector for the RSA exponentiation core (ports m, e, n, go, r, d).
- Buffers host message words in a small FIFO and latches the public key (e, n).
- Runs one core operation per message: pulses the core's go low for one cycle, then holds it high, then waits for d.
- Returns each result, or an error-flagged word, on a valid/ready output stream.

Parameters:
BITS, 32, datapath width of message, key and result.
DEPTH, 4, input FIFO depth in words (power of 2, >=2).
TIMEOUT, 4096, maximum RUN cycles before the operation is aborted.

Ports:
clk  in  1  clock; all state updates on posedge.
aresetn  in  1  asynchronous active-low reset.
key_we  in  1  load key_e/key_n this cycle.
key_e  in  BITS  public exponent.
key_n  in  BITS  modulus.
in_valid  in  1  host message word valid.
in_data  in  BITS  message word.
in_ready  out  1  FIFO not full.
rsa_m  out  BITS  message to core.
rsa_e  out  BITS  exponent to core.
rsa_n  out  BITS  modulus to core.
rsa_go  out  1  core run / active-low core reset.
rsa_r  in  BITS  core result.
rsa_d  in  1  core done (held high while core is in DONE).
out_valid  out  1  result valid.
out_data  out  BITS  result word.
out_err  out  1  result is an error word.
out_ready  in  1  downstream accepts.
busy  out  1  state != IDLE.
key_err  out  1  sticky: key_we while busy, or key_n < 2.
done_count  out  16  results handed off; wraps 0xFFFF -> 0.

Behaviour:
Reset (aresetn=0, async):
- All outputs and state go to 0: in_ready=0 during reset, then 1; rsa_go=0; out_valid=0; key_err=0; done_count=0.
- FIFO is emptied; key_valid is cleared; state = IDLE.
- Reset mid-operation drops rsa_go immediately, which also resets the core.

Key load:
- key_we in IDLE with key_n >= 2: latch e and n; key_valid=1.
- key_n < 2: ignore the key, key_valid unchanged, set key_err.
- key_we while busy: ignore the key, set key_err.
- rsa_e and rsa_n are driven from the latched registers.

Input FIFO:
- Push when in_valid & in_ready.
- Registered output, no fall-through: a word pushed in cycle t is poppable from t+1.
- When full, in_ready=0 and in_valid is ignored.
- Pointers wrap modulo DEPTH; a separate count distinguishes full from empty.

FSM (one-hot):
- IDLE: rsa_go=0. If FIFO non-empty and key_valid, pop head into rsa_m and go to CHECK.
- CHECK (1 cycle, rsa_go=0): if rsa_m >= n, set out_data=rsa_m, out_err=1, go to OUT (core not run). Otherwise go to RUN.
- RUN: rsa_go=1; tmo counter increments each cycle.
  - On the first cycle rsa_d=1: capture rsa_r into out_data, out_err=0, go to OUT.
  - If tmo reaches TIMEOUT-1 with rsa_d=0: out_data=0, out_err=1, go to OUT.
  - The go low-to-high edge occurs on entry to RUN, giving the core at least 1 full reset cycle (from CHECK).
- OUT: rsa_go=0; out_valid=1; out_data/out_err held stable until out_ready.
  - On the handshake: done_count++, go to IDLE.
  - Back-to-back messages therefore cost at least 3 overhead cycles (IDLE, CHECK, OUT).

Additional rules:
- rsa_d is ignored outside RUN.
- A stale rsa_d=1 on the first RUN cycle cannot occur, because the core was held in reset during CHECK.
- Host pushes during RUN/OUT are accepted while the FIFO is not full. Push and pop in the same cycle leave the count unchanged.
- Width: rsa_m/e/n/r are all BITS wide; the comparison rsa_m >= n is unsigned.

Test Plan:
- Key e=3, n=33; push m=5 -> rsa_go low 1 cycle then high; after core done: out_data=26, out_err=0, done_count=1.
- Key e=10, n=1000; push 2, 7, 3 back-to-back -> outputs in order 24, 249, 49. No word is lost while the core is busy; in_ready stays 1.
- Key n=33; push m=40 -> rsa_go never rises; out_data=40, out_err=1 within 3 cycles of the push.
- Core model holds rsa_d=0, TIMEOUT=64 -> out_valid with out_data=0, out_err=1 after 64 RUN cycles; rsa_go drops in OUT.
- DEPTH=4, core busy; push 6 words -> in_ready falls after the 4th buffered word. Hold out_ready=0 for 10 cycles -> out_data stable and no pop occurs. Key_we during RUN -> key_err=1, key unchanged.
- Assert aresetn=0 mid-RUN -> same cycle: rsa_go=0, out_valid=0, FIFO empty. After release, a new key and m=5 (e=3, n=33) yields 26.
